// File: rtl/prod_accum_pkg.sv
// Shared types and default widths for the product accumulator.
// Optional saturation is selected with the PROD_ACCUM_SAT_EN macro.
package prod_accum_pkg;

  localparam int P_W   = 32;
  localparam int ACC_W = 40;
  localparam int LEN_W = 8;

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/prod_accum_acc_adder.sv
// Combinational accumulator adder with carry out of ACC_W.
// With PROD_ACCUM_SAT_EN defined the result clamps to all-ones on carry.
module acc_adder #(
  parameter int P_W   = prod_accum_pkg::P_W,
  parameter int ACC_W = prod_accum_pkg::ACC_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [P_W-1:0]   p,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  localparam int SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] full;

`ifdef PROD_ACCUM_SAT_EN
  // Once clamped, any further non-zero add carries again, so the clamp is self-sustaining.
  function automatic logic [ACC_W-1:0] sat_clamp(input logic [SUM_W-1:0] x);
    return x[ACC_W] ? {ACC_W{1'b1}} : x[ACC_W-1:0];
  endfunction
`else
  function automatic logic [ACC_W-1:0] wrap_mod(input logic [SUM_W-1:0] x);
    return x[ACC_W-1:0];
  endfunction
`endif

  assign full  = {1'b0, acc} + SUM_W'(p);
  assign carry = full[ACC_W];

`ifdef PROD_ACCUM_SAT_EN
  assign sum = sat_clamp(full);
`else
  assign sum = wrap_mod(full);
`endif

endmodule

// File: rtl/prod_accum.sv
// Frame accumulator for the approximate multiplier product stream.
// Saturating add instead of modulo wrap when PROD_ACCUM_SAT_EN is defined.
module prod_accum #(
  parameter int P_W   = prod_accum_pkg::P_W,
  parameter int ACC_W = prod_accum_pkg::ACC_W,
  parameter int LEN_W = prod_accum_pkg::LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [P_W-1:0]   p_in,
  input  logic             p_valid,
  output logic             p_ready,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             busy,
  output logic             ovf
);

  import prod_accum_pkg::*;

  state_t             state;
  logic [ACC_W-1:0]   acc_p0;
  logic [LEN_W-1:0]   cnt_p0;
  logic               flag_p0;
  logic               vld_p0;
  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;

  assign p_ready = (state == ACCUM);
  assign vld_p0  = p_valid & p_ready;

  acc_adder #(
    .P_W   (P_W),
    .ACC_W (ACC_W)
  ) u_acc_adder (
    .acc   (acc_p0),
    .p     (p_in),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Frame control: the final transfer writes the completed sum straight to the output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_p0    <= '0;
      cnt_p0    <= '0;
      flag_p0   <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
      busy      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len != '0) begin
              state   <= ACCUM;
              acc_p0  <= '0;
              cnt_p0  <= len;
              flag_p0 <= 1'b0;
            end else begin
              state     <= HOLD;
              sum_out   <= '0;
              sum_valid <= 1'b1;
              ovf       <= 1'b0;
            end
          end
        end
        ACCUM: begin
          if (vld_p0) begin
            acc_p0  <= add_sum;
            cnt_p0  <= cnt_p0 - LEN_W'(1);
            flag_p0 <= flag_p0 | add_carry;
            if (cnt_p0 == LEN_W'(1)) begin
              state     <= HOLD;
              sum_out   <= add_sum;
              sum_valid <= 1'b1;
              ovf       <= flag_p0 | add_carry;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state     <= IDLE;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          sum_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
